// File: rtl/rle_job_scheduler_pkg.sv
// Shared types for the RLE job scheduler: queued descriptor layout, FSM states
// and a saturating increment used by the cycle counters.
package rle_pkg;

  localparam int unsigned RLE_TAG_W = 8;

  typedef struct packed {
    logic [31:0]          msg_addr;
    logic [31:0]          msg_size;
    logic [31:0]          rle_addr;
    logic [RLE_TAG_W-1:0] tag;
  } rle_job_t;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWaitDone,
    StReport,
    StGap
  } rle_sched_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/rle_job_scheduler_if.sv
// Host descriptor, core control and result handshakes of the RLE job scheduler.
// The slave modport is the scheduler's view; master is the host/core side.
interface rle_job_scheduler_if;

  logic                            job_valid;
  logic                            job_ready;
  logic [31:0]                     job_message_addr;
  logic [31:0]                     job_message_size;
  logic [31:0]                     job_rle_addr;
  logic                            rle_start;
  logic [31:0]                     rle_message_addr;
  logic [31:0]                     rle_message_size;
  logic [31:0]                     rle_addr;
  logic                            rle_done;
  logic [31:0]                     rle_size;
  logic                            res_valid;
  logic                            res_ready;
  logic [rle_pkg::RLE_TAG_W-1:0]   res_tag;
  logic [31:0]                     res_rle_size;
  logic [31:0]                     res_cycles;
  logic                            res_err;
  logic                            busy;

  modport master (
    output job_valid, job_message_addr, job_message_size, job_rle_addr,
    output rle_done, rle_size, res_ready,
    input  job_ready, rle_start, rle_message_addr, rle_message_size, rle_addr,
    input  res_valid, res_tag, res_rle_size, res_cycles, res_err, busy
  );

  modport slave (
    input  job_valid, job_message_addr, job_message_size, job_rle_addr,
    input  rle_done, rle_size, res_ready,
    output job_ready, rle_start, rle_message_addr, rle_message_size, rle_addr,
    output res_valid, res_tag, res_rle_size, res_cycles, res_err, busy
  );

endinterface

// File: rtl/rle_job_fifo.sv
// Synchronous descriptor FIFO; pointers carry one wrap bit so full and empty
// are distinguishable with all DEPTH entries usable.
module rle_job_fifo
  import rle_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push_i,
  input  rle_job_t wdata_i,
  input  logic     pop_i,
  output rle_job_t rdata_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr_q, rd_ptr_q;
  rle_job_t    mem_q [DEPTH];

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/rle_job_scheduler.sv
// Sequences queued descriptors through the RLE core one at a time: start pulse,
// wait for done (optional watchdog), report result, then enforce an idle gap.
module rle_job_scheduler
  import rle_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 10,
  parameter int unsigned TIMEOUT      = 0
) (
  input logic                clk,
  input logic                reset,
  rle_job_scheduler_if.slave bus
);

  rle_sched_state_e     state_q, state_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [31:0]          lat_q, lat_d;
  logic [RLE_TAG_W-1:0] tag_q;
  rle_job_t             cur_job_q, cur_job_d;
  logic                 rle_start_q, res_valid_q;
  logic [RLE_TAG_W-1:0] res_tag_q, res_tag_d;
  logic [31:0]          res_size_q, res_size_d;
  logic [31:0]          res_cycles_q, res_cycles_d;
  logic                 res_err_q, res_err_d;
  logic                 fifo_full, fifo_empty, fifo_pop, push, timeout_hit;
  rle_job_t             fifo_wdata, fifo_rdata;

  assign push       = bus.job_valid && !fifo_full;
  assign fifo_wdata = '{msg_addr: bus.job_message_addr, msg_size: bus.job_message_size,
                        rle_addr: bus.job_rle_addr, tag: tag_q};

  rle_job_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (push),
    .wdata_i(fifo_wdata),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // cnt_q holds the number of wait cycles already spent before this one.
  assign timeout_hit = (TIMEOUT != 0) && (sat_inc(cnt_q) >= TIMEOUT);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lat_d        = lat_q;
    cur_job_d    = cur_job_q;
    res_tag_d    = res_tag_q;
    res_size_d   = res_size_q;
    res_cycles_d = res_cycles_q;
    res_err_d    = res_err_q;
    fifo_pop     = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          cur_job_d = fifo_rdata;
          cnt_d     = '0;
          lat_d     = '0;
          state_d   = StLaunch;
        end
      end
      StLaunch: begin
        lat_d = sat_inc(lat_q);
        if (cnt_q == START_CYCLES - 1) begin
          cnt_d   = '0;
          state_d = StWaitDone;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StWaitDone: begin
        lat_d = sat_inc(lat_q);
        cnt_d = sat_inc(cnt_q);
        // done takes priority over a watchdog expiring in the same cycle
        if (bus.rle_done || timeout_hit) begin
          res_tag_d    = cur_job_q.tag;
          res_cycles_d = sat_inc(lat_q);
          res_err_d    = !bus.rle_done;
          res_size_d   = bus.rle_done ? bus.rle_size : '0;
          state_d      = StReport;
        end
      end
      StReport: begin
        if (bus.res_ready) begin
          cnt_d   = '0;
          state_d = (GAP_CYCLES == 0) ? StIdle : StGap;
        end
      end
      StGap: begin
        if (cnt_q == GAP_CYCLES - 1) state_d = StIdle;
        else                         cnt_d   = cnt_q + 32'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      lat_q        <= '0;
      tag_q        <= '0;
      cur_job_q    <= '0;
      rle_start_q  <= 1'b0;
      res_valid_q  <= 1'b0;
      res_tag_q    <= '0;
      res_size_q   <= '0;
      res_cycles_q <= '0;
      res_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lat_q        <= lat_d;
      cur_job_q    <= cur_job_d;
      rle_start_q  <= (state_d == StLaunch);
      res_valid_q  <= (state_d == StReport);
      res_tag_q    <= res_tag_d;
      res_size_q   <= res_size_d;
      res_cycles_q <= res_cycles_d;
      res_err_q    <= res_err_d;
      if (push) tag_q <= tag_q + RLE_TAG_W'(1);
    end
  end

  assign bus.job_ready        = !fifo_full;
  assign bus.busy             = (state_q != StIdle) || !fifo_empty;
  assign bus.rle_start        = rle_start_q;
  assign bus.rle_message_addr = cur_job_q.msg_addr;
  assign bus.rle_message_size = cur_job_q.msg_size;
  assign bus.rle_addr         = cur_job_q.rle_addr;
  assign bus.res_valid        = res_valid_q;
  assign bus.res_tag          = res_tag_q;
  assign bus.res_rle_size     = res_size_q;
  assign bus.res_cycles       = res_cycles_q;
  assign bus.res_err          = res_err_q;

endmodule

// File: tb/tb_rle_job_scheduler.sv
// Bench for rle_job_scheduler: directed and random jobs against a fake RLE core
// and a queue-based model of expected results.
module tb_rle_job_scheduler;
  import rle_pkg::*;

  localparam int unsigned DEPTH        = 4;
  localparam int unsigned START_CYCLES = 2;
  localparam int unsigned GAP_CYCLES   = 10;
  localparam int unsigned TIMEOUT      = 50;
  localparam int unsigned WAIT_LIMIT   = 400;

  // delay: wait cycles until done is sampled high; 0 means the core never finishes
  typedef struct {
    logic [31:0] ma;
    logic [31:0] ms;
    logic [31:0] ra;
    int unsigned delay;
    logic [31:0] size;
    logic [7:0]  tag;
  } job_t;

  logic        clk = 1'b0;
  logic        reset;
  int          checks = 0;
  int          errors = 0;
  int unsigned tag_ctr = 0;
  job_t        exp_q[$];
  job_t        core_q[$];
  int unsigned widths_q[$];
  int unsigned gaps_q[$];

  rle_job_scheduler_if bus ();

  rle_job_scheduler #(
    .DEPTH       (DEPTH),
    .START_CYCLES(START_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Fake core: done drops while start is high, rises `delay` cycles after start ends.
  initial begin : core_model
    job_t        cur;
    bit          armed;
    bit          prev_start;
    int unsigned cnt;
    armed = 0; prev_start = 0; cnt = 0;
    bus.rle_done = 1'b0;
    bus.rle_size = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        armed = 0; prev_start = 0; bus.rle_done = 1'b0;
      end else begin
        if (bus.rle_start) begin
          if (!prev_start && core_q.size() > 0) begin
            cur = core_q.pop_front();
            armed = (cur.delay != 0);
            cnt = 0;
          end
          bus.rle_done = 1'b0;
        end else if (armed) begin
          cnt++;
          if (cnt == cur.delay) begin
            bus.rle_done = 1'b1;
            bus.rle_size = cur.size;
            armed = 0;
          end
        end
        prev_start = bus.rle_start;
      end
    end
  end

  // Records start pulse widths and idle cycles between result acceptance and next launch.
  initial begin : start_monitor
    int unsigned run;
    int unsigned idle;
    bit          measuring;
    run = 0; idle = 0; measuring = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        run = 0; measuring = 0;
      end else begin
        if (bus.rle_start) begin
          run++;
          if (measuring) begin gaps_q.push_back(idle); measuring = 0; end
        end else begin
          if (run != 0) widths_q.push_back(run);
          run = 0;
          if (measuring) idle++;
        end
        if (bus.res_valid && bus.res_ready) begin measuring = 1; idle = 0; end
      end
    end
  end

  task automatic push(input logic [31:0] ma, input logic [31:0] ms, input logic [31:0] ra,
                      input int unsigned delay, input logic [31:0] size);
    job_t        j;
    bit          accepted = 0;
    int unsigned n = 0;
    bus.job_valid        = 1'b1;
    bus.job_message_addr = ma;
    bus.job_message_size = ms;
    bus.job_rle_addr     = ra;
    while (!accepted && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
      if (bus.job_ready) begin
        @(posedge clk); #1;
        accepted = 1;
      end
    end
    bus.job_valid = 1'b0;
    chk("push_accepted", accepted, 1);
    if (accepted) begin
      j.ma = ma; j.ms = ms; j.ra = ra; j.delay = delay; j.size = size;
      j.tag = tag_ctr[7:0];
      tag_ctr++;
      exp_q.push_back(j);
      core_q.push_back(j);
    end
  endtask

  task automatic get_result(input int unsigned hold);
    job_t        e;
    int unsigned n = 0;
    int unsigned w;
    int unsigned g;
    bit          ok;
    logic [31:0] xs, xc;
    while (!bus.res_valid && n < WAIT_LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    chk("res_valid_seen", bus.res_valid, 1);
    if (bus.res_valid && exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      ok = (e.delay != 0) && (e.delay <= TIMEOUT);
      xs = ok ? e.size : 32'd0;
      xc = START_CYCLES + (ok ? e.delay : TIMEOUT);
      for (int i = 0; i < int'(hold); i++) begin
        chk("hold_valid", bus.res_valid, 1);
        chk("hold_size", bus.res_rle_size, xs);
        chk("hold_no_start", bus.rle_start, 0);
        @(posedge clk); #1;
      end
      chk("res_tag", bus.res_tag, e.tag);
      chk("res_rle_size", bus.res_rle_size, xs);
      chk("res_err", bus.res_err, !ok);
      chk("res_cycles", bus.res_cycles, xc);
      chk("rle_message_addr", bus.rle_message_addr, e.ma);
      chk("rle_message_size", bus.rle_message_size, e.ms);
      chk("rle_addr", bus.rle_addr, e.ra);
      chk("start_width_seen", widths_q.size() > 0, 1);
      if (widths_q.size() > 0) begin
        w = widths_q.pop_front();
        chk("start_width", w, START_CYCLES);
      end
      if (gaps_q.size() > 0) begin
        g = gaps_q.pop_front();
        chk("launch_gap_min", g >= GAP_CYCLES + 1, 1);
      end
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      chk("res_valid_drop", bus.res_valid, 0);
    end
  endtask

  initial begin : global_timeout
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin : stimulus
    int unsigned n;
    bus.job_valid        = 1'b0;
    bus.job_message_addr = '0;
    bus.job_message_size = '0;
    bus.job_rle_addr     = '0;
    bus.res_ready        = 1'b0;
    reset                = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rle_start", bus.rle_start, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_job_ready", bus.job_ready, 1);
    chk("rst_rle_message_addr", bus.rle_message_addr, 0);
    chk("rst_rle_addr", bus.rle_addr, 0);
    chk("rst_res_tag", bus.res_tag, 0);
    chk("rst_res_cycles", bus.res_cycles, 0);
    chk("rst_res_rle_size", bus.res_rle_size, 0);
    chk("rst_res_err", bus.res_err, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", bus.busy, 0);

    // Single job and launch latency
    push(32'h0, 32'd48, 32'hC8, 40, 32'd12);
    chk("launch_t0_start", bus.rle_start, 0);
    chk("busy_after_push", bus.busy, 1);
    @(posedge clk); #1;
    chk("launch_t1_start", bus.rle_start, 1);
    chk("launch_rle_addr", bus.rle_addr, 32'hC8);
    get_result(0);

    // Back-to-back
    push(32'h0, 32'd48, 32'hC8, 30, 32'd12);
    push(32'h30, 32'd51, 32'h12C, 25, 32'd76);
    get_result(0);
    get_result(0);

    // FIFO full: one popped plus DEPTH queued, sixth descriptor refused
    for (int i = 0; i < 5; i++)
      push(32'h100 * i, 32'd64 + i, 32'h8000 + 32'h100 * i, 45, 32'd10 + i);
    chk("full_job_ready", bus.job_ready, 0);
    chk("full_busy", bus.busy, 1);
    bus.job_valid = 1'b1;
    bus.job_message_addr = 32'h600;
    repeat (5) begin
      @(posedge clk); #1;
      chk("full_hold_ready", bus.job_ready, 0);
    end
    bus.job_valid = 1'b0;
    repeat (5) get_result(0);

    // Backpressure with a queued job behind it
    push(32'h1, 32'h2, 32'h3, 20, 32'd33);
    push(32'h4, 32'h5, 32'h6, 5, 32'd44);
    get_result(20);
    get_result(0);

    // Watchdog, done exactly at the limit, one past the limit, then a normal job
    push(32'hA0, 32'd1, 32'hB0, 0, 32'd7);
    push(32'hA1, 32'd2, 32'hB1, TIMEOUT, 32'd8);
    push(32'hA2, 32'd3, 32'hB2, TIMEOUT + 1, 32'd9);
    push(32'hA3, 32'd4, 32'hB3, 10, 32'd5);
    repeat (4) get_result(0);

    // Random bursts
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 4);
      for (int j = 0; j < int'(n); j++)
        push($urandom, $urandom, $urandom, $urandom_range(1, 60), $urandom);
      for (int j = 0; j < int'(n); j++)
        get_result($urandom_range(0, 3));
    end

    // Reset during WAIT_DONE with two jobs queued
    for (int i = 0; i < 3; i++) push(32'hC00 + i, 32'd9, 32'hD00 + i, 40, 32'd3);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_rle_start", bus.rle_start, 0);
    chk("midrst_res_valid", bus.res_valid, 0);
    chk("midrst_job_ready", bus.job_ready, 1);
    chk("midrst_busy", bus.busy, 0);
    exp_q.delete();
    core_q.delete();
    widths_q.delete();
    gaps_q.delete();
    tag_ctr = 0;
    @(posedge clk);
    @(posedge clk); #3;
    reset = 1'b0;
    push(32'hDEAD, 32'd7, 32'hBEEF, 8, 32'd99);
    get_result(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
